// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and FSM states.
package data_mem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational little-endian lane steering: store byte mask and replicated write word,
// load extraction with sign/zero extension, and the misalignment flag.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  i_byteOffset,
    input  logic [1:0]  i_accessSize,
    input  logic        i_unsigned,
    input  logic [31:0] i_writeData,
    input  logic [31:0] i_readWord,
    output logic [3:0]  o_byteMask,
    output logic [31:0] o_writeWord,
    output logic [31:0] o_loadValue,
    output logic        o_misaligned
);

    logic [4:0]  w_shift;
    logic [31:0] w_shiftedRead;

    assign w_shift       = {i_byteOffset, 3'b000};
    assign w_shiftedRead = i_readWord >> w_shift;

    // Write data is replicated across lanes so the mask alone picks the target bytes.
    always_comb begin
        o_byteMask   = 4'b0000;
        o_writeWord  = 32'h0;
        o_loadValue  = 32'h0;
        o_misaligned = 1'b0;
        case (i_accessSize)
            SIZE_BYTE: begin
                o_byteMask  = 4'b0001 << i_byteOffset;
                o_writeWord = {4{i_writeData[7:0]}};
                o_loadValue = i_unsigned ? {24'h0, w_shiftedRead[7:0]}
                                         : {{24{w_shiftedRead[7]}}, w_shiftedRead[7:0]};
            end
            SIZE_HALF: begin
                o_byteMask   = i_byteOffset[1] ? 4'b1100 : 4'b0011;
                o_writeWord  = {2{i_writeData[15:0]}};
                o_loadValue  = i_unsigned ? {16'h0, w_shiftedRead[15:0]}
                                          : {{16{w_shiftedRead[15]}}, w_shiftedRead[15:0]};
                o_misaligned = i_byteOffset[0];
            end
            SIZE_WORD: begin
                o_byteMask   = 4'b1111;
                o_writeWord  = i_writeData;
                o_loadValue  = i_readWord;
                o_misaligned = (i_byteOffset != 2'b00);
            end
            default: begin
                o_byteMask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: one request at a time, WAIT_STATES cycles of latency,
// byte/half/word access with error reporting on misaligned, out-of-range or conflicting requests.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_reqValid,
    output logic        o_reqReady,
    input  logic [31:0] i_address,
    input  logic [31:0] i_writeData,
    input  logic        i_memWrite,
    input  logic        i_memRead,
    input  logic [1:0]  i_accessSize,
    input  logic        i_unsigned,
    output logic        o_respValid,
    output logic [31:0] o_readData,
    output logic        o_addrError
);

    localparam int IDXW = $clog2(DEPTH);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_waitCnt;
    logic [3:0]  w_nextWaitCnt;

    logic [31:0] r_address;
    logic [31:0] r_writeData;
    logic        r_memWrite;
    logic        r_memRead;
    logic [1:0]  r_accessSize;
    logic        r_unsigned;
    logic [31:0] r_readData;
    logic        r_addrError;

    logic [31:0] r_mem [DEPTH];

    logic        w_handshake;
    logic        w_commit;
    logic        w_useInputs;
    logic [31:0] w_address;
    logic [31:0] w_writeData;
    logic        w_memWrite;
    logic        w_memRead;
    logic [1:0]  w_accessSize;
    logic        w_unsigned;
    logic [IDXW-1:0] w_wordIdx;
    logic [31:0] w_readWord;
    logic [3:0]  w_byteMask;
    logic [31:0] w_writeWord;
    logic [31:0] w_loadValue;
    logic        w_misaligned;
    logic        w_outOfRange;
    logic        w_error;

    assign o_reqReady  = (r_state == ST_IDLE);
    assign o_respValid = (r_state == ST_RESP);
    assign o_readData  = r_readData;
    assign o_addrError = r_addrError;

    assign w_handshake = (r_state == ST_IDLE) && i_reqValid && (i_memRead || i_memWrite);

    // With zero wait states the access commits on the handshake edge itself, so the
    // live inputs stand in for the not-yet-latched request fields.
    assign w_useInputs  = (r_state == ST_IDLE);
    assign w_address    = w_useInputs ? i_address    : r_address;
    assign w_writeData  = w_useInputs ? i_writeData  : r_writeData;
    assign w_memWrite   = w_useInputs ? i_memWrite   : r_memWrite;
    assign w_memRead    = w_useInputs ? i_memRead    : r_memRead;
    assign w_accessSize = w_useInputs ? i_accessSize : r_accessSize;
    assign w_unsigned   = w_useInputs ? i_unsigned   : r_unsigned;

    assign w_commit = ((r_state == ST_BUSY) && (r_waitCnt <= 4'd1))
                   || (w_handshake && (WAIT_STATES == 0));

    assign w_wordIdx    = w_address[IDXW+1:2];
    assign w_readWord   = r_mem[w_wordIdx];
    assign w_outOfRange = ({2'b00, w_address[31:2]} >= 32'(DEPTH));
    assign w_error      = w_misaligned || w_outOfRange || (w_accessSize == 2'b11)
                       || (w_memRead && w_memWrite);

    mem_lane_align u_laneAlign (
        .i_byteOffset (w_address[1:0]),
        .i_accessSize (w_accessSize),
        .i_unsigned   (w_unsigned),
        .i_writeData  (w_writeData),
        .i_readWord   (w_readWord),
        .o_byteMask   (w_byteMask),
        .o_writeWord  (w_writeWord),
        .o_loadValue  (w_loadValue),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    if (WAIT_STATES == 0) begin
                        w_nextState = ST_RESP;
                    end else begin
                        w_nextState   = ST_BUSY;
                        w_nextWaitCnt = 4'(WAIT_STATES);
                    end
                end
            end
            ST_BUSY: begin
                w_nextWaitCnt = r_waitCnt - 4'd1;
                if (r_waitCnt <= 4'd1) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_waitCnt    <= 4'd0;
            r_readData   <= 32'h0;
            r_addrError  <= 1'b0;
            r_address    <= 32'h0;
            r_writeData  <= 32'h0;
            r_memWrite   <= 1'b0;
            r_memRead    <= 1'b0;
            r_accessSize <= SIZE_BYTE;
            r_unsigned   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            if (w_handshake) begin
                r_address    <= i_address;
                r_writeData  <= i_writeData;
                r_memWrite   <= i_memWrite;
                r_memRead    <= i_memRead;
                r_accessSize <= i_accessSize;
                r_unsigned   <= i_unsigned;
            end
            if (w_commit) begin
                r_addrError <= w_error;
                if (!w_error && w_memRead) begin
                    r_readData <= w_loadValue;
                end
            end
        end
    end

    // Reset on the commit edge wins, so a store abandoned by reset never lands.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit && !w_error && w_memWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (w_byteMask[k]) begin
                    r_mem[w_wordIdx][8*k +: 8] <= w_writeWord[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized accesses
// compared against a byte-array reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqValid0;
    logic        reqReady;
    logic        reqReady0;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [1:0]  accessSize;
    logic        unsignedLd;
    logic        respValid;
    logic        respValid0;
    logic [31:0] readData;
    logic [31:0] readData0;
    logic        addrError;
    logic        addrError0;

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0]  refMem [0:4095];
    logic [31:0] refReadData;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .WAIT_STATES(1)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_reqValid   (reqValid),
        .o_reqReady   (reqReady),
        .i_address    (address),
        .i_writeData  (writeData),
        .i_memWrite   (memWrite),
        .i_memRead    (memRead),
        .i_accessSize (accessSize),
        .i_unsigned   (unsignedLd),
        .o_respValid  (respValid),
        .o_readData   (readData),
        .o_addrError  (addrError)
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_reqValid   (reqValid0),
        .o_reqReady   (reqReady0),
        .i_address    (address),
        .i_writeData  (writeData),
        .i_memWrite   (memWrite),
        .i_memRead    (memRead),
        .i_accessSize (accessSize),
        .i_unsigned   (unsignedLd),
        .o_respValid  (respValid0),
        .o_readData   (readData0),
        .o_addrError  (addrError0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory as a flat byte array, errors straight from the access rules.
    task automatic modelAccess(input logic wr, input logic rd, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic expErr);
        int n;
        logic [31:0] v;
        expErr = (size == 2'b11) || (wr && rd) || (addr >= 32'h1000)
              || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        if (expErr) return;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (wr) begin
            for (int i = 0; i < n; i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(refMem[int'(addr) + i]) << (8*i));
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
            refReadData = v;
        end
    endtask

    // Issues one request from IDLE (called #1 after a rising edge) and waits for its response.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int lat,
                                 output logic err, output logic [31:0] rdata);
        memWrite   = wr;
        memRead    = rd;
        accessSize = size;
        unsignedLd = uns;
        address    = addr;
        writeData  = wdata;
        reqValid   = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        lat   = 0;
        err   = 1'b0;
        rdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            if (respValid) begin
                lat   = c;
                err   = addrError;
                rdata = readData;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checkOutput("respPulse", {31'h0, respValid}, 32'h0);
    endtask

    task automatic doAccess(input string tag, input logic wr, input logic rd,
                            input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic err, output logic [31:0] rdata);
        int lat;
        logic expErr;
        applyStimulus(wr, rd, size, uns, addr, wdata, lat, err, rdata);
        modelAccess(wr, rd, size, uns, addr, wdata, expErr);
        checkOutput({tag, ".lat"}, 32'(lat), 32'd2);
        checkOutput({tag, ".err"}, {31'h0, err}, {31'h0, expErr});
        checkOutput({tag, ".data"}, rdata, refReadData);
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int          readyCnt;
        int          readyCnt0;
        int          respCnt;
        int          respCnt0;
        int          overlap;

        for (int i = 0; i < 4096; i++) refMem[i] = 8'h00;
        refReadData = 32'h0;
        reset      = 1'b1;
        reqValid   = 1'b0;
        reqValid0  = 1'b0;
        address    = 32'h0;
        writeData  = 32'h0;
        memWrite   = 1'b0;
        memRead    = 1'b0;
        accessSize = 2'b00;
        unsignedLd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst.ready", {31'h0, reqReady}, 32'h1);
        checkOutput("rst.resp", {31'h0, respValid}, 32'h0);
        checkOutput("rst.data", readData, 32'h0);
        checkOutput("rst.err", {31'h0, addrError}, 32'h0);

        for (int w = 0; w < 64; w++) doAccess("init", 1'b1, 1'b0, 2'b10, 1'b0, 32'(4*w), 32'h0, e, d);

        doAccess("t1.sw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, e, d);
        doAccess("t1.lw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, e, d);
        checkOutput("t1.lwConst", d, 32'h12345678);

        doAccess("t2.lb3", 1'b0, 1'b1, 2'b00, 1'b0, 32'h3, 32'h0, e, d);
        checkOutput("t2.lb3Const", d, 32'h00000012);
        doAccess("t2.lb0", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, e, d);
        checkOutput("t2.lb0Const", d, 32'h00000078);
        doAccess("t2.sb1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h1, 32'h80, e, d);
        doAccess("t2.lb1", 1'b0, 1'b1, 2'b00, 1'b0, 32'h1, 32'h0, e, d);
        checkOutput("t2.lb1Const", d, 32'hFFFFFF80);
        doAccess("t2.lbu1", 1'b0, 1'b1, 2'b00, 1'b1, 32'h1, 32'h0, e, d);
        checkOutput("t2.lbu1Const", d, 32'h00000080);

        doAccess("t3.sw8", 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'hFFFFFFFF, e, d);
        doAccess("t3.lh", 1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0, e, d);
        checkOutput("t3.lhConst", d, 32'hFFFFFFFF);
        doAccess("t3.lhu", 1'b0, 1'b1, 2'b01, 1'b1, 32'hA, 32'h0, e, d);
        checkOutput("t3.lhuConst", d, 32'h0000FFFF);
        doAccess("t3.sw4", 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0000FFFF, e, d);
        doAccess("t3.sb5", 1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h000000AB, e, d);
        doAccess("t3.lw4", 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, e, d);
        checkOutput("t3.lw4Const", d, 32'h0000ABFF);

        doAccess("t4.swMis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h16, 32'h0000000F, e, d);
        checkOutput("t4.swMisErr", {31'h0, e}, 32'h1);
        doAccess("t4.lw14", 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0, e, d);
        checkOutput("t4.lw14Const", d, 32'h0);
        doAccess("t4.range", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h0, e, d);
        checkOutput("t4.rangeErr", {31'h0, e}, 32'h1);
        doAccess("t4.both", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, e, d);
        checkOutput("t4.bothErr", {31'h0, e}, 32'h1);
        doAccess("t4.size11", 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, e, d);
        doAccess("t4.lhOdd", 1'b0, 1'b1, 2'b01, 1'b0, 32'h1, 32'h0, e, d);

        // Request with neither read nor write must be ignored.
        address  = 32'h0;
        reqValid = 1'b1;
        respCnt  = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (respValid) respCnt++;
        end
        reqValid = 1'b0;
        checkOutput("noop.resp", 32'(respCnt), 32'd0);
        checkOutput("noop.ready", {31'h0, reqReady}, 32'h1);

        // Continuous requests: one acceptance per 3 cycles (1 wait) and per 2 cycles (0 wait).
        memRead    = 1'b1;
        accessSize = 2'b10;
        address    = 32'h0;
        reqValid   = 1'b1;
        reqValid0  = 1'b1;
        readyCnt = 0; readyCnt0 = 0; respCnt = 0; respCnt0 = 0; overlap = 0;
        repeat (12) begin
            @(negedge clk);
            if (reqReady) readyCnt++;
            if (reqReady0) readyCnt0++;
            if (respValid) respCnt++;
            if (respValid0) respCnt0++;
            if (reqReady && respValid) overlap++;
        end
        @(posedge clk); #1;
        reqValid  = 1'b0;
        reqValid0 = 1'b0;
        memRead   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5.ready1", 32'(readyCnt), 32'd4);
        checkOutput("t5.resp1", 32'(respCnt), 32'd4);
        checkOutput("t5.ready0", 32'(readyCnt0), 32'd6);
        checkOutput("t5.resp0", 32'(respCnt0), 32'd6);
        checkOutput("t5.overlap", 32'(overlap), 32'd0);
        modelAccess(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, e);

        // Reset while the store is in BUSY (also the commit edge for one wait state).
        memWrite   = 1'b1;
        accessSize = 2'b10;
        address    = 32'h20;
        writeData  = 32'hDEADBEEF;
        reqValid   = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        memWrite = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        respCnt = 0;
        repeat (4) begin
            if (respValid) respCnt++;
            @(posedge clk); #1;
        end
        refReadData = 32'h0;
        checkOutput("t6.noResp", 32'(respCnt), 32'd0);
        checkOutput("t6.data", readData, 32'h0);
        doAccess("t6.lw20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, e, d);
        checkOutput("t6.lw20Const", d, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic        wr;
            logic        rd;
            logic [31:0] addr;
            int          op;
            op   = $urandom_range(0, 15);
            wr   = (op < 7) || (op == 15);
            rd   = (op >= 7);
            addr = ($urandom_range(0, 15) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                                : 32'($urandom_range(0, 255));
            doAccess("rand", wr, rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     addr, $urandom, e, d);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
